// File: rtl/jtframe_pocket_pkg.sv
// Shared definitions for the Pocket programming path: output FSM encoding
// and the width of one buffered write entry.
package jtframe_pocket_pkg;

  // Output request FSM: IDLE waits for buffered words, REQ holds a request
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } prog_st_e;

  // One FIFO entry is {word address, 16-bit data, 2-bit active-low mask}
  function automatic int entry_width(input int aw);
    return aw + 16 + 2;
  endfunction

endpackage

// File: rtl/jtframe_pocket_prog_fifo.sv
// Single-clock show-ahead FIFO. A push on a full FIFO is accepted only when a
// pop frees a slot in the same cycle; otherwise the caller sees it dropped.
module jtframe_pocket_prog_fifo #(
  parameter int W  = 40,
  parameter int AW = 3
) (
  input  logic         clk_rom,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW:0]   wr_ptr_r;
  logic [AW:0]   rd_ptr_r;
  logic          wr_en_s;
  logic          rd_en_s;

  // Extra pointer bit tells full from empty when the indexes match
  assign empty   = (wr_ptr_r == rd_ptr_r);
  assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign rd_en_s = pop & ~empty;
  assign wr_en_s = push & (~full | rd_en_s);
  assign dout    = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update; reset discards every buffered entry
  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Storage write; contents need no reset since the pointers gate them
  always_ff @(posedge clk_rom) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/jtframe_pocket_prog.sv
// Packs the ioctl byte stream into 16-bit words with active-low byte masks,
// buffers them and drives the SDRAM programming port with a we/rdy handshake.
module jtframe_pocket_prog
  import jtframe_pocket_pkg::*;
#(
  parameter int AW      = 22,
  parameter int FIFO_AW = 3,
  parameter int SWAB    = 0
) (
  input  logic          clk_rom,
  input  logic          rst,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  input  logic          ioctl_wr,
  input  logic          downloading,
  output logic [AW-1:0] prog_addr,
  output logic [15:0]   prog_data,
  output logic [1:0]    prog_mask,
  output logic          prog_we,
  input  logic          prog_rdy,
  output logic          busy,
  output logic          ovf
);

  localparam int   EW     = entry_width(AW);
  localparam logic SWAB_B = (SWAB != 0);

  // Pending (partially assembled) word
  logic [AW-1:0] paddr_r;
  logic [15:0]   pdata_r;
  logic [1:0]    pmask_r;
  logic          pvalid_r;
  logic [AW-1:0] nx_paddr_s;
  logic [15:0]   nx_pdata_s;
  logic [1:0]    nx_pmask_s;
  logic          nx_pvalid_s;

  // Download window tracking
  logic          dl_r;
  logic          flush_pend_r;
  logic          nx_flush_pend_s;
  logic          flush_req_s;
  logic          dl_rise_s;

  // Byte decode
  logic          lane_s;
  logic [AW-1:0] waddr_s;
  logic [15:0]   merge_data_s;
  logic [1:0]    merge_mask_s;
  logic [15:0]   new_data_s;
  logic [1:0]    new_mask_s;
  logic          unused_s;

  // FIFO interface
  logic          push_s;
  logic [EW-1:0] push_din_s;
  logic          pop_s;
  logic [EW-1:0] fifo_dout_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic [AW-1:0] fifo_addr_s;
  logic [15:0]   fifo_data_s;
  logic [1:0]    fifo_mask_s;
  logic          drop_s;

  // Output FSM and registered outputs
  prog_st_e      st_r;
  prog_st_e      st_nx_s;
  logic          load_s;
  logic          we_nx_s;
  logic [AW-1:0] prog_addr_r;
  logic [15:0]   prog_data_r;
  logic [1:0]    prog_mask_r;
  logic          prog_we_r;
  logic          busy_r;
  logic          ovf_r;

  // Byte address bits above the word range alias and are not used
  assign unused_s = ^ioctl_addr[24:AW+1];

  assign lane_s       = ioctl_addr[0] ^ SWAB_B;
  assign waddr_s      = ioctl_addr[AW:1];
  assign merge_data_s = lane_s ? {ioctl_dout, pdata_r[7:0]} : {pdata_r[15:8], ioctl_dout};
  assign merge_mask_s = lane_s ? (pmask_r & 2'b01) : (pmask_r & 2'b10);
  assign new_data_s   = lane_s ? {ioctl_dout, 8'h00} : {8'h00, ioctl_dout};
  assign new_mask_s   = lane_s ? 2'b01 : 2'b10;

  // A flush is due on the download fall, or one cycle later if a byte collided
  assign dl_rise_s   = downloading & ~dl_r;
  assign flush_req_s = (dl_r & ~downloading) | flush_pend_r;

  // Assembler: merge, start or push the pending word; at most one push per cycle
  always_comb begin
    push_s          = 1'b0;
    push_din_s      = {paddr_r, pdata_r, pmask_r};
    nx_paddr_s      = paddr_r;
    nx_pdata_s      = pdata_r;
    nx_pmask_s      = pmask_r;
    nx_pvalid_s     = pvalid_r;
    nx_flush_pend_s = 1'b0;
    if (ioctl_wr) begin
      nx_flush_pend_s = flush_req_s;
      if (pvalid_r && (waddr_s == paddr_r) && pmask_r[lane_s]) begin
        if (merge_mask_s == 2'b00) begin
          push_s      = 1'b1;
          push_din_s  = {paddr_r, merge_data_s, merge_mask_s};
          nx_pvalid_s = 1'b0;
        end else begin
          nx_pdata_s  = merge_data_s;
          nx_pmask_s  = merge_mask_s;
        end
        nx_pdata_s = merge_data_s;
        nx_pmask_s = merge_mask_s;
      end else begin
        push_s      = pvalid_r;
        nx_paddr_s  = waddr_s;
        nx_pdata_s  = new_data_s;
        nx_pmask_s  = new_mask_s;
        nx_pvalid_s = 1'b1;
      end
    end else if (flush_req_s && pvalid_r) begin
      push_s      = 1'b1;
      nx_pvalid_s = 1'b0;
    end else begin
      nx_pvalid_s = pvalid_r;
    end
  end

  // Assembler and download-window state
  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      paddr_r      <= {AW{1'b0}};
      pdata_r      <= 16'h0000;
      pmask_r      <= 2'b11;
      pvalid_r     <= 1'b0;
      dl_r         <= 1'b0;
      flush_pend_r <= 1'b0;
    end else begin
      paddr_r      <= nx_paddr_s;
      pdata_r      <= nx_pdata_s;
      pmask_r      <= nx_pmask_s;
      pvalid_r     <= nx_pvalid_s;
      dl_r         <= downloading;
      flush_pend_r <= nx_flush_pend_s;
    end
  end

  jtframe_pocket_prog_fifo #(
    .W  (EW),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk_rom (clk_rom),
    .rst     (rst),
    .push    (push_s),
    .din     (push_din_s),
    .pop     (pop_s),
    .dout    (fifo_dout_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  assign {fifo_addr_s, fifo_data_s, fifo_mask_s} = fifo_dout_s;

  // A push is lost only when the FIFO is full and nothing leaves this cycle
  assign drop_s = push_s & fifo_full_s & ~pop_s;

  // Output FSM next state: pop into the output register whenever it frees up
  always_comb begin
    st_nx_s = st_r;
    pop_s   = 1'b0;
    load_s  = 1'b0;
    we_nx_s = prog_we_r;
    case (st_r)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          load_s  = 1'b1;
          we_nx_s = 1'b1;
          st_nx_s = ST_REQ;
        end else begin
          we_nx_s = 1'b0;
        end
      end
      ST_REQ: begin
        if (prog_rdy) begin
          if (!fifo_empty_s) begin
            pop_s   = 1'b1;
            load_s  = 1'b1;
            we_nx_s = 1'b1;
          end else begin
            we_nx_s = 1'b0;
            st_nx_s = ST_IDLE;
          end
        end else begin
          we_nx_s = 1'b1;
        end
      end
      default: begin
        we_nx_s = 1'b0;
        st_nx_s = ST_IDLE;
      end
    endcase
  end

  // FSM state and programming-port output registers
  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      st_r        <= ST_IDLE;
      prog_we_r   <= 1'b0;
      prog_addr_r <= {AW{1'b0}};
      prog_data_r <= 16'h0000;
      prog_mask_r <= 2'b11;
    end else begin
      st_r      <= st_nx_s;
      prog_we_r <= we_nx_s;
      if (load_s) begin
        prog_addr_r <= fifo_addr_s;
        prog_data_r <= fifo_data_s;
        prog_mask_r <= fifo_mask_s;
      end
    end
  end

  // Sticky overflow (cleared when a new download starts) and registered busy
  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      ovf_r  <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      if (drop_s) begin
        ovf_r <= 1'b1;
      end else if (dl_rise_s) begin
        ovf_r <= 1'b0;
      end
      busy_r <= downloading | pvalid_r | ~fifo_empty_s | prog_we_r;
    end
  end

  assign prog_addr = prog_addr_r;
  assign prog_data = prog_data_r;
  assign prog_mask = prog_mask_r;
  assign prog_we   = prog_we_r;
  assign busy      = busy_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_jtframe_pocket_prog.sv
// Scoreboard bench: a byte-level reference model queues expected SDRAM words
// for a SWAB=0 and a SWAB=1 instance; a monitor pops them on each handshake.
module tb_jtframe_pocket_prog;

  localparam int AW = 22;

  typedef struct {
    logic [AW-1:0] a;
    logic [15:0]   d;
    logic [1:0]    m;
  } exp_t;

  logic          clk_rom = 1'b0;
  logic          rst;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic          ioctl_wr;
  logic          downloading;
  logic          prog_rdy;
  logic [AW-1:0] pa0, pa1;
  logic [15:0]   pd0, pd1;
  logic [1:0]    pm0, pm1;
  logic          pw0, pw1, busy0, busy1, ovf0, ovf1;

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   rdy_rand = 1'b0;

  exp_t q0[$];
  exp_t q1[$];

  // Reference model state, index = SWAB setting
  bit            pv  [2];
  bit [1:0]      hv  [2];
  logic [AW-1:0] pwd [2];
  logic [15:0]   pdt [2];
  int            cap [2];
  bit            exp_ovf [2];

  always #5 clk_rom = ~clk_rom;

  jtframe_pocket_prog #(.AW(AW), .FIFO_AW(3), .SWAB(0)) u_dut (
    .clk_rom(clk_rom), .rst(rst), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wr(ioctl_wr), .downloading(downloading), .prog_addr(pa0), .prog_data(pd0),
    .prog_mask(pm0), .prog_we(pw0), .prog_rdy(prog_rdy), .busy(busy0), .ovf(ovf0)
  );

  jtframe_pocket_prog #(.AW(AW), .FIFO_AW(3), .SWAB(1)) u_dut_swab (
    .clk_rom(clk_rom), .rst(rst), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wr(ioctl_wr), .downloading(downloading), .prog_addr(pa1), .prog_data(pd1),
    .prog_mask(pm1), .prog_we(pw1), .prog_rdy(prog_rdy), .busy(busy1), .ovf(ovf1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_clear();
    for (int s = 0; s < 2; s++) begin
      pv[s] = 1'b0; hv[s] = 2'b00; cap[s] = 1 << 30; exp_ovf[s] = 1'b0;
    end
    q0.delete();
    q1.delete();
  endtask

  // Emit the pending word of model s; storage limit models a stalled port
  task automatic model_emit(input int s);
    exp_t e;
    e.a = pwd[s]; e.d = pdt[s]; e.m = ~hv[s];
    pv[s] = 1'b0;
    if (cap[s] > 0) begin
      cap[s]--;
      if (s == 0) q0.push_back(e);
      else        q1.push_back(e);
    end else begin
      exp_ovf[s] = 1'b1;
    end
  endtask

  task automatic model_byte(input logic [24:0] a, input logic [7:0] d);
    int lane;
    logic [AW-1:0] w;
    w = a[AW:1];
    for (int s = 0; s < 2; s++) begin
      lane = int'(a[0]) ^ s;
      if (pv[s] && pwd[s] == w && !hv[s][lane]) begin
        hv[s][lane] = 1'b1;
        pdt[s][lane*8 +: 8] = d;
        if (hv[s] == 2'b11) model_emit(s);
      end else begin
        if (pv[s]) model_emit(s);
        pv[s] = 1'b1; pwd[s] = w; hv[s] = 2'b00; pdt[s] = 16'h0000;
        hv[s][lane] = 1'b1;
        pdt[s][lane*8 +: 8] = d;
      end
    end
  endtask

  task automatic model_flush();
    for (int s = 0; s < 2; s++) begin
      if (pv[s]) model_emit(s);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk_rom);
    #1;
    if (rdy_rand) prog_rdy = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    model_byte(a, d);
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic send_byte_fall(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1; downloading = 1'b0;
    model_byte(a, d);
    model_flush();
    tick();
    ioctl_wr = 1'b0;
    tick();
  endtask

  task automatic set_dl(input logic v);
    logic was;
    was = downloading;
    downloading = v;
    if (was && !v) model_flush();
    tick();
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while ((q0.size() != 0 || q1.size() != 0) && k < 400) begin
      tick();
      k++;
    end
    check(name, 32'(q0.size() + q1.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; ioctl_wr = 1'b0; downloading = 1'b0;
    model_clear();
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  // ---------------- monitor ----------------
  task automatic mon_word(input int s, input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] m);
    exp_t e;
    logic [15:0] lm;
    n_checks++;
    if ((s == 0 && q0.size() == 0) || (s == 1 && q1.size() == 0)) begin
      n_fail++;
      $display("FAIL unexpected_write_swab%0d: got addr %h data %h mask %b, required no write", s, a, d, m);
    end else begin
      if (s == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      lm = {{8{~e.m[1]}}, {8{~e.m[0]}}};
      if (a !== e.a || m !== e.m || (d & lm) !== (e.d & lm)) begin
        n_fail++;
        $display("FAIL word_swab%0d: got addr %h data %h mask %b, required addr %h data %h mask %b",
                 s, a, d, m, e.a, e.d, e.m);
      end
    end
  endtask

  // A request is accepted at the next rising edge when we and rdy are both high
  always @(negedge clk_rom) begin
    if (!rst && prog_rdy) begin
      if (pw0) mon_word(0, pa0, pd0, pm0);
      if (pw1) mon_word(1, pa1, pd1, pm1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [AW-1:0] snap_a;
    logic [15:0]   snap_d;
    logic [1:0]    snap_m;
    logic [24:0]   cur;
    int            k;

    rst = 1'b1; ioctl_addr = 25'd0; ioctl_dout = 8'h00; ioctl_wr = 1'b0;
    downloading = 1'b0; prog_rdy = 1'b0;
    model_clear();
    #1;
    check("rst_we",   32'(pw0), 32'd0);
    check("rst_addr", 32'(pa0), 32'd0);
    check("rst_data", 32'(pd0), 32'd0);
    check("rst_mask", 32'(pm0), 32'd3);
    check("rst_ovf",  32'(ovf0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    do_reset();

    // Sequential bytes, both SWAB settings, latency of first write
    prog_rdy = 1'b1;
    set_dl(1'b1);
    send_byte(25'h000, 8'h11);
    send_byte(25'h001, 8'h22);
    check("lat_edge_c", 32'(pw0), 32'd0);
    send_byte(25'h002, 8'h33);
    check("lat_edge_c1", 32'(pw0), 32'd1);
    check("busy_dl", 32'(busy0), 32'd1);
    send_byte(25'h003, 8'h44);
    set_dl(1'b0);
    wait_drain("drain_seq");

    // Single odd byte flushed on download end, then busy falls
    set_dl(1'b1);
    send_byte(25'h105, 8'hAB);
    tick();
    set_dl(1'b0);
    wait_drain("drain_single");
    tick(); tick(); tick();
    check("busy_idle", 32'(busy0), 32'd0);

    // Non-adjacent bytes, then a byte coinciding with the download fall
    set_dl(1'b1);
    send_byte(25'h010, 8'h5A);
    send_byte(25'h020, 8'hC3);
    tick();
    set_dl(1'b0);
    set_dl(1'b1);
    send_byte(25'h041, 8'h77);
    send_byte_fall(25'h050, 8'h66);
    wait_drain("drain_partial");

    // Stalled port: one word in the output register plus 8 in the FIFO
    do_reset();
    prog_rdy = 1'b0;
    cap[0] = 9; cap[1] = 9;
    set_dl(1'b1);
    for (int i = 0; i < 40; i++) begin
      send_byte(25'h200 + 25'(i), 8'(8'h80 + i));
      if (i == 5) begin
        snap_a = pa0; snap_d = pd0; snap_m = pm0;
      end
    end
    tick(); tick();
    check("stall_we",    32'(pw0), 32'd1);
    check("stall_addr",  32'(pa0), 32'(snap_a));
    check("stall_data",  32'(pd0), 32'(snap_d));
    check("stall_mask",  32'(pm0), 32'(snap_m));
    check("ovf_set",     32'(ovf0), 32'(exp_ovf[0]));
    check("ovf_set_swab", 32'(ovf1), 32'(exp_ovf[1]));
    set_dl(1'b0);
    prog_rdy = 1'b1;
    wait_drain("drain_ovf");
    check("ovf_sticky", 32'(ovf0), 32'd1);
    set_dl(1'b1);
    tick();
    check("ovf_clear", 32'(ovf0), 32'd0);
    set_dl(1'b0);
    cap[0] = 1 << 30; cap[1] = 1 << 30;

    // Reset mid-transfer with three words still buffered
    do_reset();
    prog_rdy = 1'b0;
    set_dl(1'b1);
    for (int i = 0; i < 8; i++) send_byte(25'h040 + 25'(i), 8'($urandom));
    check("pre_rst_we", 32'(pw0), 32'd1);
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    check("mid_rst_we",   32'(pw0), 32'd0);
    check("mid_rst_addr", 32'(pa0), 32'd0);
    check("mid_rst_data", 32'(pd0), 32'd0);
    check("mid_rst_mask", 32'(pm0), 32'd3);
    check("mid_rst_busy", 32'(busy0), 32'd0);
    downloading = 1'b0;
    prog_rdy = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("post_rst_we", 32'(pw0), 32'd0);

    // Randomized stream with random back-pressure and aliasing addresses
    rdy_rand = 1'b1;
    set_dl(1'b1);
    cur = 25'(32'h00000100);
    for (int i = 0; i < 160; i++) begin
      k = 0;
      while (q0.size() > 6 && k < 300) begin
        tick();
        k++;
      end
      if (k >= 300) check("throttle_timeout", 32'(q0.size()), 32'd6);
      k = $urandom_range(0, 19);
      if (k < 12)      cur = cur + 25'd1;
      else if (k < 16) cur = {cur[24:1], 1'($urandom_range(0, 1))};
      else             cur = 25'($urandom);
      if ($urandom_range(0, 29) == 0) begin
        set_dl(1'b0);
        set_dl(1'b1);
      end
      send_byte(cur, 8'($urandom));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    end
    set_dl(1'b0);
    wait_drain("drain_rand");
    check("rand_ovf", 32'(ovf0), 32'd0);
    rdy_rand = 1'b0;
    prog_rdy = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("end_queue", 32'(q0.size() + q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
